// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the latency bound.
package dmem_pkg;

    // Access size/sign encodings as they appear in the RV32I load/store funct3 field
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Largest supported read latency; sizes the wait counter
    localparam int RD_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: store byte-enables and
// merged write word, load extract/extend, and alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] mem_word_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] rd_word_o,
    output logic        misaligned_o
);

    logic [31:0] src_rep;
    logic [31:0] shifted;

    // Byte enables, replicated store source and alignment from the access size
    always_comb begin
        byte_en_o    = 4'b0000;
        src_rep      = wr_data_i;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            2'b00: begin
                byte_en_o = 4'b0001 << lane_i;
                src_rep   = {4{wr_data_i[7:0]}};
            end
            2'b01: begin
                byte_en_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                src_rep      = {2{wr_data_i[15:0]}};
                misaligned_o = lane_i[0];
            end
            2'b10: begin
                byte_en_o    = 4'b1111;
                misaligned_o = (lane_i != 2'b00);
            end
            default: begin
                byte_en_o = 4'b0000;
            end
        endcase
    end

    // Merge: enabled lanes take the replicated store data, others keep memory
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_word_o[8*gi +: 8] = byte_en_o[gi] ? src_rep[8*gi +: 8]
                                                    : mem_word_i[8*gi +: 8];
    end

    assign shifted = mem_word_i >> {lane_i, 3'b000};

    // Load extract: addressed lane moved to bit 0, then sign or zero extended
    always_comb begin
        rd_word_o = shifted;
        case (funct3_i)
            F3_B:    rd_word_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rd_word_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rd_word_o = {24'd0, shifted[7:0]};
            F3_HU:   rd_word_o = {16'd0, shifted[15:0]};
            default: rd_word_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: posted sub-word
// stores, extended loads after RD_LATENCY cycles, err pulse on bad requests.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 9,
    parameter int DEPTH      = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    localparam int CNT_W = $clog2(RD_LATENCY_MAX);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic [ADDR_W-3:0] word_idx;
    logic [DATA_W-1:0] mem_word;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic              misaligned;
    logic              f3_ok;
    logic              illegal;
    logic              accept;
    logic              do_store;
    logic              do_load;

    assign word_idx = addr[ADDR_W-1:2];
    assign mem_word = mem_q[word_idx];

    dmem_lane_align u_align (
        .lane_i       (addr[1:0]),
        .funct3_i     (funct3),
        .wr_data_i    (wr_data),
        .mem_word_i   (mem_word),
        .byte_en_o    (byte_en),
        .wr_word_o    (wr_word),
        .rd_word_o    (rd_word),
        .misaligned_o (misaligned)
    );

    // Stores accept only signed encodings; loads also accept bu/hu
    assign f3_ok    = wr ? (funct3 inside {F3_B, F3_H, F3_W})
                         : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign illegal  = (wr && rd) || misaligned || !f3_ok;
    assign accept   = ready && (wr || rd);
    assign do_store = accept && wr && !illegal;
    assign do_load  = accept && rd && !illegal;

    assign ready    = (state_q != WAIT);
    assign rd_valid = (state_q == RESP);
    assign rd_data  = rd_data_q;
    assign err      = err_q;

    // Storage: posted store at the acceptance edge, cleared on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_store) begin
            mem_q[word_idx] <= wr_word;
        end
    end

    // Next state: loads go to RESP directly or through WAIT; anything else idles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        rd_data_d = rd_data_q;
        err_d     = accept && illegal;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (do_load) begin
                    if (RD_LATENCY == 1) begin
                        state_d   = RESP;
                        rd_data_d = rd_word;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                        load_d  = rd_word;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = RESP;
                    rd_data_d = load_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, snapshot and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            load_q    <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (read latency 1, 3, 4) share one
// request bus gated by sel; a byte-array model predicts responses into a
// scoreboard that a negedge monitor drains.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_r, rd_r;
    logic [8:0]  addr_r;
    logic [2:0]  f3_r;
    logic [31:0] wd_r;
    int          sel;

    logic        ready_w    [NDUT];
    logic        rd_valid_w [NDUT];
    logic        err_w      [NDUT];
    logic [31:0] rd_data_w  [NDUT];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        dmem_responder #(
            .RD_LATENCY((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr_r && (sel == gi)),
            .rd       (rd_r && (sel == gi)),
            .addr     (addr_r),
            .funct3   (f3_r),
            .wr_data  (wd_r),
            .ready    (ready_w[gi]),
            .rd_valid (rd_valid_w[gi]),
            .rd_data  (rd_data_w[gi]),
            .err      (err_w[gi])
        );
    end

    typedef struct {
        int          dut;
        bit          is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_m [NDUT][512];
    int          vectors = 0;
    int          miscompares = 0;
    int          edges = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < 512; i++)
                mem_m[k][i] = 8'h00;
    endtask

    // Reference: byte-addressed little-endian memory with RV32I access rules
    function automatic void model(int k, bit w, bit r, logic [8:0] a, logic [2:0] f,
                                  logic [31:0] d, output bit bad, output logic [31:0] res);
        int          size;
        bit          uns;
        logic [31:0] v;
        size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : (f[1:0] == 2'd2) ? 4 : 0;
        uns  = f[2];
        res  = 32'h0;
        bad  = (w && r) || (size == 0);
        if (!bad) bad = (uns && (size == 4 || w)) || ((int'(a) % size) != 0);
        if (bad) return;
        if (w) begin
            for (int i = 0; i < size; i++) mem_m[k][int'(a) + i] = d[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_m[k][int'(a) + i]) << (8*i));
            if (!uns && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            res = v;
        end
    endfunction

    // Present a request to dut k, hold it until ready, predict its outcome
    task automatic issue(int k, bit w, bit r, logic [8:0] a, logic [2:0] f,
                         logic [31:0] d, output int acc);
        bit          bad;
        logic [31:0] res;
        int          waited;
        exp_t        e;
        sel = k; wr_r = w; rd_r = r; addr_r = a; f3_r = f; wd_r = d;
        acc = -1;
        waited = 0;
        @(negedge clk);
        while (!ready_w[k] && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!ready_w[k]) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: dut %0d ready=0, required 1", k);
            wr_r = 1'b0; rd_r = 1'b0;
            return;
        end
        model(k, w, r, a, f, d, bad, res);
        acc = edges + 1;
        e.dut = k;
        if (bad) begin
            e.is_err = 1'b1; e.data = 32'h0; e.due = edges + 1;
            exp_q.push_back(e);
        end else if (r) begin
            e.is_err = 1'b0; e.data = res; e.due = edges + lat_of(k);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        wr_r = 1'b0; rd_r = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every response must match the oldest expectation for that dut, on time
    always @(negedge clk) begin : monitor
        int idx;
        for (int k = 0; k < NDUT; k++) begin
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
                if (exp_q[j].dut == k) begin idx = j; break; end
            end
            if (rd_valid_w[k] || err_w[k]) begin
                if (idx < 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: dut %0d rd_valid=%b err=%b, required none",
                             k, rd_valid_w[k], err_w[k]);
                end else begin
                    check($sformatf("dut%0d_kind", k), {30'd0, rd_valid_w[k], err_w[k]},
                          {30'd0, !exp_q[idx].is_err, exp_q[idx].is_err});
                    if (!exp_q[idx].is_err)
                        check($sformatf("dut%0d_rd_data", k), rd_data_w[k], exp_q[idx].data);
                    check($sformatf("dut%0d_resp_cycle", k), edges, exp_q[idx].due);
                    exp_q.delete(idx);
                end
            end else if (idx >= 0 && exp_q[idx].due <= edges) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_resp: dut %0d no response at edge %0d, required one (err=%b data=%h)",
                         k, edges, exp_q[idx].is_err, exp_q[idx].data);
                exp_q.delete(idx);
            end
        end
        if (sel == 0 && !reset) check("dut0_ready_always", {31'd0, ready_w[0]}, 32'd1);
    end

    initial begin
        int acc_a, acc_b, waited;
        sel = 0; wr_r = 1'b0; rd_r = 1'b0; addr_r = '0; f3_r = '0; wd_r = '0;
        clear_model();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_ready%0d", k),    {31'd0, ready_w[k]},    32'd1);
            check($sformatf("rst_rd_valid%0d", k), {31'd0, rd_valid_w[k]}, 32'd0);
            check($sformatf("rst_rd_data%0d", k),  rd_data_w[k],           32'd0);
            check($sformatf("rst_err%0d", k),      {31'd0, err_w[k]},      32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Latency 1: word, byte and halfword traffic, back to back
        issue(0, 1, 0, 9'h010, F3_W,  32'hDEADBEEF, acc_a);
        issue(0, 0, 1, 9'h010, F3_W,  32'h0,        acc_a);
        issue(0, 1, 0, 9'h013, F3_B,  32'h00000080, acc_a);
        issue(0, 0, 1, 9'h013, F3_B,  32'h0,        acc_a);
        issue(0, 0, 1, 9'h013, F3_BU, 32'h0,        acc_a);
        issue(0, 0, 1, 9'h010, F3_W,  32'h0,        acc_a);
        issue(0, 1, 0, 9'h022, F3_H,  32'h00001234, acc_a);
        issue(0, 0, 1, 9'h022, F3_HU, 32'h0,        acc_a);
        issue(0, 0, 1, 9'h020, F3_W,  32'h0,        acc_a);
        // Illegal requests, then confirm the word is untouched
        issue(0, 0, 1, 9'h011, F3_H,   32'h0,        acc_a);
        issue(0, 1, 0, 9'h022, F3_W,   32'hFFFFFFFF, acc_a);
        issue(0, 1, 1, 9'h020, F3_W,   32'hFFFFFFFF, acc_a);
        issue(0, 0, 1, 9'h020, 3'b011, 32'h0,        acc_a);
        issue(0, 1, 0, 9'h020, F3_BU,  32'hFFFFFFFF, acc_a);
        issue(0, 0, 1, 9'h020, F3_W,   32'h0,        acc_a);
        idle(3);

        // Latency 3: a held store is accepted only once the load reaches RESP
        issue(1, 1, 0, 9'h010, F3_W, 32'hDEADBEEF, acc_a);
        issue(1, 0, 1, 9'h010, F3_W, 32'h0,        acc_a);
        issue(1, 1, 0, 9'h010, F3_W, 32'h11223344, acc_b);
        check("sw_held_until_resp", 32'(acc_b - acc_a), 32'd3);
        issue(1, 0, 1, 9'h010, F3_H, 32'h0, acc_a);
        issue(1, 0, 1, 9'h012, F3_B, 32'h0, acc_a);
        idle(6);

        // Latency 4: reset during WAIT drops the load and clears memory
        issue(2, 1, 0, 9'h010, F3_W, 32'hCAFEF00D, acc_a);
        issue(2, 0, 1, 9'h010, F3_W, 32'h0,        acc_a);
        issue(2, 0, 1, 9'h010, F3_W, 32'h0,        acc_a);
        wr_r = 1'b0; rd_r = 1'b0;
        @(posedge clk); #1;
        check("dut2_ready_in_wait", {31'd0, ready_w[2]}, 32'd0);
        reset = 1'b1;
        exp_q.delete();
        clear_model();
        #1;
        check("midrst_ready",    {31'd0, ready_w[2]},    32'd1);
        check("midrst_rd_valid", {31'd0, rd_valid_w[2]}, 32'd0);
        check("midrst_rd_data",  rd_data_w[2],           32'd0);
        check("midrst_err",      {31'd0, err_w[2]},      32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        issue(2, 0, 1, 9'h010, F3_W, 32'h0, acc_a);
        idle(6);

        // Randomized traffic on every latency, including illegal encodings
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 60; n++) begin
                int op;
                bit w, r;
                op = $urandom_range(0, 9);
                w  = (op <= 4);
                r  = (op == 0) || (op >= 5);
                issue(k, w, r, 9'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), $urandom, acc_a);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(6);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
